branch_redirect_ctrl: RTL
=========================

# branch_redirect_ctrl

- Sequences the pipeline response to a taken branch resolved in EX.
- Converts the branch unit's `isBranchTaken`/`branchPC` into three actions:
  - a PC redirect request held until fetch accepts it;
  - flushes of the IF/ID and ID/EX pipeline registers;
  - a drain window that suppresses wrong-path branch resolution.
- Sits between the EX-stage branch unit and the PC/fetch logic and pipeline-register flush inputs.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 2: cycles after redirect acceptance during which EX resolution is ignored.
- `STAT_W`, default 32: width of statistics counters (only with `BRANCH_STATS_EN`).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ex_valid`  in  1  instruction in EX is valid (not a bubble).
- `isBranchTaken`  in  1  branch unit taken decision for EX instruction.
- `branchPC`  in  32  branch unit target address.
- `fetch_ready`  in  1  PC register accepts a redirect this cycle.
- `redirect_valid`  out  1  redirect request to PC mux.
- `redirect_pc`  out  32  redirect target.
- `isFlush_IFID`  out  1  clear IF/ID register at next edge.
- `isFlush_IDEX`  out  1  clear ID/EX register at next edge.
- `ex_kill`  out  1  EX result must not commit (drain window).
- `br_state`  out  2  current FSM state, for debug.
- `stat_taken`  out  STAT_W  taken-branch count (`BRANCH_STATS_EN` only).
- `stat_penalty`  out  STAT_W  redirect-wait plus drain cycles (`BRANCH_STATS_EN` only).

## Operation
States (2-bit encoding): IDLE=0, PENDING=1, DRAIN=2. Encoding 3 is unused and returns to IDLE.

Trigger:
- `take = ex_valid & isBranchTaken & (state==IDLE)`.

IDLE:
- Outputs are combinational from inputs: `redirect_valid=take`, `redirect_pc=branchPC`, `isFlush_IFID=isFlush_IDEX=take`.
- On `take`:
  - capture `branchPC` into `tgt_q`;
  - if `fetch_ready` is high, go to DRAIN and load `drain_cnt=DRAIN_CYCLES-1`;
  - otherwise go to PENDING.

PENDING:
- Outputs: `redirect_valid=1`, `redirect_pc=tgt_q`, `isFlush_IFID=1`, `isFlush_IDEX=0`.
- `isFlush_IFID` stays high so wrong-path fetches are discarded every cycle.
- Stays in PENDING until `fetch_ready` is high, then goes to DRAIN.
- `isBranchTaken` is ignored.

DRAIN:
- Outputs: `redirect_valid=0`, `ex_kill=1`, flushes 0.
- `isBranchTaken` is ignored.
- Decrements `drain_cnt` each cycle; at 0, goes to IDLE.

Other rules:
- `DRAIN_CYCLES=0`: acceptance goes straight to IDLE and DRAIN is never entered.
- A taken branch presented on the first IDLE cycle after DRAIN is honored normally.
- `ex_valid=0` with `isBranchTaken=1` is ignored in all states.
- `redirect_pc` is `branchPC` in IDLE and `tgt_q` in PENDING/DRAIN. `tgt_q` is never modified outside an IDLE `take`.

## Timing
Reset values (synchronous, takes effect at the edge where `reset=1`):
- state=IDLE, `tgt_q=0`, `drain_cnt=0`, stats=0.
- Outputs during and after reset: `redirect_valid=0`, flushes 0, `ex_kill=0`, `br_state=0`.

Reset mid-PENDING or mid-DRAIN:
- Pending redirect is dropped with no further flush.
- The next cycle is IDLE.

Latency:
- Redirect and flush are asserted in the same cycle the branch is in EX (zero-cycle, combinational path).
- The PC loads the target at the same edge when `fetch_ready=1`.
- Minimum branch penalty: 2 flushed slots.
- Each extra `fetch_ready=0` cycle adds one IF/ID flush cycle.

Handshake:
- The redirect transfers on the edge where `redirect_valid & fetch_ready`.
- `redirect_valid` never drops before acceptance, except on reset.
- `redirect_pc` is stable while `redirect_valid` is held.

## Configuration
`BRANCH_STATS_EN` defined:
- `stat_taken` increments on every `take`.
- `stat_penalty` increments every cycle in PENDING or DRAIN, plus the IDLE `take` cycle.
- Both counters saturate at all-ones and clear on reset.

`BRANCH_STATS_EN` undefined:
- Stat ports and counters are absent.
- All other behaviour is identical.

## Structure
Shared package `simplerisc_pkg` holds:
- `br_state_t` enum (IDLE/PENDING/DRAIN, 2-bit);
- constant `BR_DRAIN_DEFAULT=2`.

One sub-module, `sat_counter` (width-parameterized saturating incrementer with synchronous clear):
- instantiated twice under `BRANCH_STATS_EN`.

The FSM, target register and drain counter stay in the top module.

## Test plan
- **Taken, fetch ready:** `ex_valid=1`, `isBranchTaken=1`, `branchPC=0x100`, `fetch_ready=1`.
  - Same cycle: `redirect_valid=1`, `redirect_pc=0x100`, both flushes=1.
  - Then 2 cycles DRAIN with `ex_kill=1`, then IDLE.
- **Fetch stalled:** `branchPC=0x40`, `fetch_ready=0` for 3 cycles, then 1.
  - 4 cycles of `redirect_valid=1`, `redirect_pc=0x40`, `isFlush_IFID=1`.
  - `isFlush_IDEX` high only on the first cycle.
  - Then DRAIN.
  - A changing `branchPC` during PENDING has no effect.
- **Branch during DRAIN:** `isBranchTaken=1`, `ex_valid=1`, `branchPC=0x200` in DRAIN cycle 1.
  - No redirect, no flush.
  - Same input on the first IDLE cycle is taken with target 0x200.
- **Bubble:** `ex_valid=0`, `isBranchTaken=1` in IDLE.
  - All outputs 0; state stays IDLE.
- **Reset in PENDING:** `reset=1` while `fetch_ready=0`.
  - Next cycle: `redirect_valid=0`, `br_state=0`, `tgt_q=0`.
- **Stats (`BRANCH_STATS_EN`):** three branches: ready, 2-cycle stall, ready.
  - `stat_taken=3`.
  - `stat_penalty=3+2+3+3=11` (DRAIN_CYCLES=2).

Source files
------------

// File: rtl/simplerisc_pkg.sv
// Shared types and constants for the simplerisc pipeline control blocks.
package simplerisc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        DRAIN   = 2'd2
    } br_state_t;

    localparam int unsigned BR_DRAIN_DEFAULT = 2;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterized saturating incrementer with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Taken-branch response sequencer: PC redirect handshake, IF/ID and ID/EX flush, wrong-path drain.
// Optional statistics counters are built when BRANCH_STATS_EN is defined.
module branch_redirect_ctrl
    import simplerisc_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = BR_DRAIN_DEFAULT,
    parameter int unsigned STAT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    input  logic        fetch_ready,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        isFlush_IFID,
    output logic        isFlush_IDEX,
    output logic        ex_kill,
    output logic [1:0]  br_state
`ifdef BRANCH_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_taken,
    output logic [STAT_W-1:0] stat_penalty
`endif
);

    localparam int unsigned CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam bit          HAS_DRAIN  = (DRAIN_CYCLES != 0);

    br_state_t        state_q;
    br_state_t        state_d;
    logic [31:0]      tgt_q;
    logic [CNT_W-1:0] drain_cnt;
    logic             take;
    logic             accept;

    assign take   = ex_valid & isBranchTaken & (state_q == IDLE);
    assign accept = fetch_ready & (take | (state_q == PENDING));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    if (!fetch_ready) begin
                        state_d = PENDING;
                    end else if (HAS_DRAIN) begin
                        state_d = DRAIN;
                    end
                end
            end
            PENDING: begin
                if (fetch_ready) begin
                    state_d = HAS_DRAIN ? DRAIN : IDLE;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Target capture and drain countdown; tgt_q only changes on an IDLE take
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q     <= '0;
            drain_cnt <= '0;
        end else begin
            if (take) begin
                tgt_q <= branchPC;
            end
            if (accept && HAS_DRAIN) begin
                drain_cnt <= CNT_W'(DRAIN_LOAD);
            end else if ((state_q == DRAIN) && (drain_cnt != '0)) begin
                drain_cnt <= drain_cnt - CNT_W'(1);
            end
        end
    end

    // Outputs; IDLE is a zero-latency path from the branch unit
    always_comb begin
        redirect_valid = 1'b0;
        redirect_pc    = tgt_q;
        isFlush_IFID   = 1'b0;
        isFlush_IDEX   = 1'b0;
        ex_kill        = 1'b0;
        br_state       = 2'd0;
        if (!reset) begin
            br_state = state_q;
            case (state_q)
                IDLE: begin
                    redirect_valid = take;
                    redirect_pc    = branchPC;
                    isFlush_IFID   = take;
                    isFlush_IDEX   = take;
                end
                PENDING: begin
                    redirect_valid = 1'b1;
                    isFlush_IFID   = 1'b1;
                end
                DRAIN: begin
                    ex_kill = 1'b1;
                end
                default: begin
                    redirect_valid = 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic penalty_inc;

    assign penalty_inc = take | (state_q == PENDING) | (state_q == DRAIN);

    sat_counter #(.W(STAT_W)) u_stat_taken (
        .clk   (clk),
        .clear (reset),
        .inc   (take),
        .count (stat_taken)
    );

    sat_counter #(.W(STAT_W)) u_stat_penalty (
        .clk   (clk),
        .clear (reset),
        .inc   (penalty_inc),
        .count (stat_penalty)
    );
`else
    // STAT_W has no effect without statistics
    if (STAT_W == 0) begin : g_no_stats
    end
`endif

endmodule
